// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode encoding, flag bit positions and multiplier iteration count.
// Latency: n/a (constants only).
// Backpressure: n/a.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS_A = 4'b0000,
    OP_PASS_B = 4'b0001,
    OP_NOT_A  = 4'b0010,
    OP_NOT_B  = 4'b0011,
    OP_ADD    = 4'b0100,
    OP_ADC    = 4'b0101,
    OP_SUB    = 4'b0110,
    OP_AND    = 4'b0111,
    OP_OR     = 4'b1000,
    OP_XOR    = 4'b1001,
    OP_LSL    = 4'b1010,
    OP_LSR    = 4'b1011,
    OP_ASR    = 4'b1100,
    OP_ROL    = 4'b1101,
    OP_ROR    = 4'b1110,
    OP_MUL    = 4'b1111
  } op_e;

  // Flags vector layout {Z,C,N,O}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  // One shift-add step per multiplier bit
  localparam int MUL_ITER = 8;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 unsigned shift-add multiplier, one partial product per clock.
// Latency: product valid (o_done high) in the MUL_ITER-th cycle after the start edge.
// Backpressure: i_start ignored while o_busy; o_done/o_product are combinational on the last step.
module alu_mul_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_product
);

  logic        r_busy;
  logic [3:0]  r_cnt;
  logic [15:0] r_mcand;
  logic [7:0]  r_mplier;
  logic [15:0] r_acc;
  logic [15:0] w_acc_nxt;
  logic        w_last;

  // Accumulator after the current step; on the last step this is the full product
  always_comb begin
    w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : 16'd0);
    w_last    = r_busy && (r_cnt == 4'(MUL_ITER - 1));
  end

  assign o_busy    = r_busy;
  assign o_done    = w_last;
  assign o_product = w_acc_nxt;

  // Load operands on start, then shift multiplicand left / multiplier right each step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= 4'd0;
      r_mcand  <= 16'd0;
      r_mplier <= 8'd0;
      r_acc    <= 16'd0;
    end else if (!r_busy) begin
      if (i_start) begin
        r_busy   <= 1'b1;
        r_cnt    <= 4'd0;
        r_mcand  <= {8'd0, i_a};
        r_mplier <= i_b;
        r_acc    <= 16'd0;
      end
    end else begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= {r_mcand[14:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[7:1]};
      r_cnt    <= r_cnt + 4'd1;
      if (w_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_unit.sv
// alu_unit: 8-bit ALU with registered OutALU/Flags{Z,C,N,O}; FunSel=1111 is MUL when ALU_MUL_EN is defined, else a no-op.
// Latency: single-cycle ops update at the accepting edge (done next cycle); MUL completes 8 edges after acceptance.
// Backpressure: start is ignored while busy; a start in the done cycle is accepted.
module alu_unit
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] FunSel,
  input  logic       start,
  input  logic       WF,
  output logic [7:0] OutALU,
  output logic [3:0] Flags,
  output logic       busy,
  output logic       done
);

  logic       w_accept;
  logic       w_is_mul;
  logic       w_busy;
  logic [7:0] w_res;
  logic       w_c;
  logic       w_o;
  logic       w_wr;
  logic [8:0] w_sum;
  logic [3:0] w_flags_nxt;

  assign w_accept = start && !w_busy;
  assign busy     = w_busy;

`ifdef ALU_MUL_EN
  logic        r_wf;
  logic        w_mul_done;
  logic [15:0] w_prod;
  logic [3:0]  w_mul_flags;

  assign w_is_mul = (FunSel == OP_MUL);

  alu_mul_seq u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_accept && w_is_mul),
    .i_a       (A),
    .i_b       (B),
    .o_busy    (w_busy),
    .o_done    (w_mul_done),
    .o_product (w_prod)
  );

  // MUL flags: Z/N from low byte, C marks a nonzero high byte, O untouched
  always_comb begin
    w_mul_flags         = Flags;
    w_mul_flags[FLAG_Z] = (w_prod[7:0] == 8'd0);
    w_mul_flags[FLAG_N] = w_prod[7];
    w_mul_flags[FLAG_C] = |w_prod[15:8];
  end

  // Remember the flag-write request for the MUL in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wf <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_wf <= WF;
    end
  end
`else
  assign w_is_mul = 1'b0;
  assign w_busy   = 1'b0;
`endif

  // Single-cycle datapath: result plus candidate C/O (held unless the op defines them)
  always_comb begin
    w_res = OutALU;
    w_c   = Flags[FLAG_C];
    w_o   = Flags[FLAG_O];
    w_wr  = 1'b1;
    w_sum = 9'd0;
    case (op_e'(FunSel))
      OP_PASS_A: w_res = A;
      OP_PASS_B: w_res = B;
      OP_NOT_A:  w_res = ~A;
      OP_NOT_B:  w_res = ~B;
      OP_ADD: begin
        w_sum = {1'b0, A} + {1'b0, B};
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_o   = (A[7] == B[7]) && (w_sum[7] != A[7]);
      end
      OP_ADC: begin
        w_sum = {1'b0, A} + {1'b0, B} + {8'd0, Flags[FLAG_C]};
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_o   = (A[7] == B[7]) && (w_sum[7] != A[7]);
      end
      OP_SUB: begin
        // Two's-complement subtract; carry-out set means no borrow
        w_sum = {1'b0, A} + {1'b0, ~B} + 9'd1;
        w_res = w_sum[7:0];
        w_c   = w_sum[8];
        w_o   = (A[7] != B[7]) && (w_sum[7] != A[7]);
      end
      OP_AND: w_res = A & B;
      OP_OR:  w_res = A | B;
      OP_XOR: w_res = A ^ B;
      OP_LSL: begin
        w_res = {A[6:0], 1'b0};
        w_c   = A[7];
      end
      OP_LSR: begin
        w_res = {1'b0, A[7:1]};
        w_c   = A[0];
      end
      OP_ASR: begin
        w_res = {A[7], A[7:1]};
        w_c   = A[0];
      end
      OP_ROL: begin
        w_res = {A[6:0], Flags[FLAG_C]};
        w_c   = A[7];
      end
      OP_ROR: begin
        w_res = {Flags[FLAG_C], A[7:1]};
        w_c   = A[0];
      end
      default: w_wr = 1'b0;  // OP_MUL: handled by the sequencer or a no-op
    endcase
    w_flags_nxt         = Flags;
    w_flags_nxt[FLAG_Z] = (w_res == 8'd0);
    w_flags_nxt[FLAG_C] = w_c;
    w_flags_nxt[FLAG_N] = w_res[7];
    w_flags_nxt[FLAG_O] = w_o;
  end

  // Result/flag registers and the one-cycle done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      OutALU <= 8'd0;
      Flags  <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept && !w_is_mul) begin
        done <= 1'b1;
        if (w_wr) begin
          OutALU <= w_res;
          if (WF) begin
            Flags <= w_flags_nxt;
          end
        end
      end
`ifdef ALU_MUL_EN
      if (w_mul_done) begin
        OutALU <= w_prod[7:0];
        done   <= 1'b1;
        if (r_wf) begin
          Flags <= w_mul_flags;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: vector table + hand-written MUL/reset sequences + randomized ops against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [3:0] FunSel = 4'd0;
  logic       start = 1'b0;
  logic       WF = 1'b0;
  logic [7:0] OutALU;
  logic [3:0] Flags;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;

  // Behavioural model state
  int m_out;
  bit m_z, m_c, m_n, m_o;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .FunSel (FunSel),
    .start  (start),
    .WF     (WF),
    .OutALU (OutALU),
    .Flags  (Flags),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] fs;
    logic       wf;
    logic [7:0] eo;
    logic [3:0] ef;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] fs, input logic wf);
    @(negedge clk);
    A = a; B = b; FunSel = fs; WF = wf; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  function automatic int sgn(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference: plain integer arithmetic on unsigned/signed interpretations
  task automatic model_step(input int a, input int b, input int fs, input bit wf);
    int r, s, ss;
    bit nc, no, wr;
    r = m_out; nc = m_c; no = m_o; wr = 1'b1;
    case (fs)
      0: r = a;
      1: r = b;
      2: r = 255 - a;
      3: r = 255 - b;
      4: begin s = a + b; r = s % 256; nc = (s > 255);
               ss = sgn(a) + sgn(b); no = (ss > 127) || (ss < -128); end
      5: begin s = a + b + int'(m_c); r = s % 256; nc = (s > 255);
               ss = sgn(a) + sgn(b) + int'(m_c); no = (ss > 127) || (ss < -128); end
      6: begin r = (a - b + 256) % 256; nc = (a >= b);
               ss = sgn(a) - sgn(b); no = (ss > 127) || (ss < -128); end
      7: r = a & b;
      8: r = a | b;
      9: r = a ^ b;
      10: begin r = (a * 2) % 256; nc = (a >= 128); end
      11: begin r = a / 2; nc = (a % 2) == 1; end
      12: begin r = a / 2 + ((a >= 128) ? 128 : 0); nc = (a % 2) == 1; end
      13: begin r = (a * 2) % 256 + int'(m_c); nc = (a >= 128); end
      14: begin r = a / 2 + int'(m_c) * 128; nc = (a % 2) == 1; end
      default: begin
`ifdef ALU_MUL_EN
        s = a * b; r = s % 256; nc = (s > 255);
`else
        wr = 1'b0;
`endif
      end
    endcase
    if (wr) begin
      m_out = r;
      if (wf) begin
        m_z = (r == 0); m_n = (r >= 128); m_c = nc; m_o = no;
      end
    end
  endtask

  task automatic rand_op(input int k);
    logic [7:0] a, b;
    logic [3:0] fs;
    logic       wf;
    int         cyc;
    a  = 8'($urandom_range(0, 255));
    b  = 8'($urandom_range(0, 255));
    fs = 4'($urandom_range(0, 15));
    wf = ($urandom_range(0, 3) != 0);
    model_step(a, b, fs, wf);
    issue(a, b, fs, wf);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
`ifdef ALU_MUL_EN
    if (fs == 4'hF) chk($sformatf("rnd%0d_mul_lat", k), cyc, 8);
    else            chk($sformatf("rnd%0d_lat", k), cyc, 0);
`else
    chk($sformatf("rnd%0d_lat", k), cyc, 0);
`endif
    chk($sformatf("rnd%0d_out fs=%0h", k, fs), OutALU, m_out);
    chk($sformatf("rnd%0d_flags fs=%0h", k, fs), Flags, {m_z, m_c, m_n, m_o});
    chk($sformatf("rnd%0d_busy", k), busy, 0);
  endtask

  initial begin
    int pulses;
    // {A, B, FunSel, WF, expected OutALU, expected {Z,C,N,O}} chained from reset
    tbl[0]  = '{8'h7F, 8'h01, 4'h4, 1'b1, 8'h80, 4'b0011};
    tbl[1]  = '{8'h18, 8'h18, 4'h6, 1'b1, 8'h00, 4'b1100};
    tbl[2]  = '{8'h81, 8'h00, 4'hA, 1'b1, 8'h02, 4'b0100};
    tbl[3]  = '{8'h80, 8'h00, 4'hD, 1'b1, 8'h01, 4'b0100};
    tbl[4]  = '{8'h40, 8'h00, 4'hD, 1'b0, 8'h81, 4'b0100};
    tbl[5]  = '{8'hFF, 8'h00, 4'h5, 1'b1, 8'h00, 4'b1100};
    tbl[6]  = '{8'hF0, 8'h3C, 4'h7, 1'b1, 8'h30, 4'b0100};
    tbl[7]  = '{8'h80, 8'h01, 4'h9, 1'b1, 8'h81, 4'b0110};
    tbl[8]  = '{8'h00, 8'h00, 4'h2, 1'b1, 8'hFF, 4'b0110};
    tbl[9]  = '{8'h00, 8'h01, 4'h6, 1'b1, 8'hFF, 4'b0010};
    tbl[10] = '{8'h80, 8'h01, 4'h6, 1'b1, 8'h7F, 4'b0101};
    tbl[11] = '{8'h81, 8'h00, 4'hC, 1'b1, 8'hC0, 4'b0111};
    tbl[12] = '{8'h02, 8'h00, 4'hE, 1'b1, 8'h81, 4'b0011};
    tbl[13] = '{8'h00, 8'h00, 4'h1, 1'b1, 8'h00, 4'b1001};
    tbl[14] = '{8'h01, 8'h00, 4'hB, 1'b1, 8'h00, 4'b1101};
    tbl[15] = '{8'h00, 8'hAA, 4'h3, 1'b1, 8'h55, 4'b0101};
    tbl[16] = '{8'h00, 8'h00, 4'h8, 1'b1, 8'h00, 4'b1101};
    tbl[17] = '{8'h80, 8'h00, 4'h0, 1'b0, 8'h80, 4'b1101};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", OutALU, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    // Back-to-back table ops: each start lands in the previous done cycle
    for (int i = 0; i < 18; i++) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].fs, tbl[i].wf);
      chk($sformatf("vec%0d_out", i), OutALU, tbl[i].eo);
      chk($sformatf("vec%0d_flags", i), Flags, tbl[i].ef);
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_busy", i), busy, 0);
    end
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);

`ifdef ALU_MUL_EN
    // MUL 0x5E*0x03 = 0x011A, with an ignored start in the middle
    issue(8'h5E, 8'h03, 4'hF, 1'b1);
    chk("mul_busy0", busy, 1);
    chk("mul_done0", done, 0);
    chk("mul_hold0", OutALU, 8'h80);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) begin
        A = 8'h01; B = 8'h01; FunSel = 4'h4; WF = 1'b1; start = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      if (i < 8) begin
        chk($sformatf("mul_busy%0d", i), busy, 1);
        chk($sformatf("mul_done%0d", i), done, 0);
        chk($sformatf("mul_hold%0d", i), OutALU, 8'h80);
      end else begin
        chk("mul_busy_end", busy, 0);
        chk("mul_done_end", done, 1);
        chk("mul_out", OutALU, 8'h1A);
        chk("mul_flags", Flags, 4'b0101);
      end
    end
    @(posedge clk); #1;
    chk("mul_done_once", done, 0);
    chk("mul_ignored_start", OutALU, 8'h1A);

    // Abort a MUL with reset in its 4th cycle
    issue(8'hFF, 8'hFF, 4'hF, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
`else
    // FunSel=1111 without the multiplier is a single-cycle no-op
    issue(8'h5E, 8'h03, 4'hF, 1'b1);
    chk("noop_out", OutALU, 8'h80);
    chk("noop_flags", Flags, 4'b1101);
    chk("noop_done", done, 1);
    chk("noop_busy", busy, 0);
    @(posedge clk); #1;
    chk("noop_busy_after", busy, 0);

    // Reset asserted while done is high
    issue(8'h7F, 8'h01, 4'h4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
`endif
    chk("abort_out", OutALU, 0);
    chk("abort_flags", Flags, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    issue(8'h7F, 8'h01, 4'h4, 1'b1);
    chk("post_rst_out", OutALU, 8'h80);
    chk("post_rst_flags", Flags, 4'b0011);
    chk("post_rst_done", done, 1);

    // Randomized ops from a fresh reset against the model
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    m_out = 0; m_z = 0; m_c = 0; m_n = 0; m_o = 0;
    for (int k = 0; k < 300; k++) begin
      rand_op(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
ALU_UNIT -- requirements
Module: alu_unit

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- A  in  8  operand A, driven by register-file output O1.
- B  in  8  operand B, driven by register-file output O2.
- FunSel  in  4  operation select, sampled with start.
- start  in  1  operation request.
- WF  in  1  flag write enable, sampled with start.
- OutALU  out  8  registered result.
- Flags  out  4  registered {Z,C,N,O}: Z=bit3, C=bit2, N=bit1, O=bit0.
- busy  out  1  multi-cycle operation in progress.
- done  out  1  one-cycle pulse marking result/flags update.

Function
REQ-002 The block SHALL accept start only when busy=0; start while busy=1 SHALL be ignored, and A/B/FunSel/WF SHALL be latched at acceptance.
REQ-003 FunSel SHALL select: 0000 A; 0001 B; 0010 ~A; 0011 ~B; 0100 A+B; 0101 A+B+C; 0110 A-B; 0111 A&B; 1000 A|B; 1001 A^B; 1010 LSL A; 1011 LSR A; 1100 ASR A; 1101 rotate-left A through C; 1110 rotate-right A through C; 1111 MUL.
REQ-004 Single-cycle ops SHALL update OutALU at the accepting edge and pulse done high for exactly the following cycle; busy SHALL stay 0.
REQ-005 Arithmetic SHALL be 8-bit modulo 256; A-B SHALL be computed as A+~B+1, with C=carry-out (C=1 when A>=B unsigned).
REQ-006 Z SHALL equal (result==0) and N SHALL equal result[7] for every op when WF=1.
REQ-007 C SHALL be updated only by add/sub (carry-out), by shifts/rotates (bit shifted out), and by MUL; all other ops SHALL hold C.
REQ-008 O SHALL be updated only by add/sub (signed overflow); all other ops SHALL hold O.
REQ-009 With WF=0, Flags SHALL hold; OutALU SHALL still update.
REQ-010 MUL SHALL be a shift-add sequence: busy=1 from the accepting edge, OutALU=low byte of A*B at the 8th following edge, with busy cleared and done pulsed at that same edge.
REQ-011 MUL flags (WF=1): Z and N from the low byte, C=1 iff the high byte is nonzero, O held.
REQ-012 OutALU SHALL hold its previous value during MUL until completion.
REQ-013 done and start SHALL be allowed back-to-back: start in the cycle done is high SHALL be accepted.

Reset
REQ-014 rst_n=0 SHALL immediately force OutALU=0x00, Flags=0000, busy=0, done=0, and the multiplier to idle, aborting any MUL in progress without completion.
REQ-015 The first start after rst_n rises SHALL be accepted normally.

Configuration
REQ-016 With macro ALU_MUL_EN defined, FunSel=1111 SHALL perform MUL per REQ-010/011.
REQ-017 Without ALU_MUL_EN, FunSel=1111 SHALL be a single-cycle no-op: OutALU and Flags hold, done pulses, busy never asserts, and no multiplier logic is instantiated.

Structure
REQ-018 A shared package alu_pkg SHALL hold the FunSel opcode constants, the flag bit indices (Z, C, N, O), and the MUL iteration count (8).
REQ-019 The multiplier SHALL be a sub-module alu_mul_seq with start/busy/done and a 16-bit product, instantiated only under ALU_MUL_EN.

Verification
REQ-020 Reset, then A=0x7F, B=0x01, FunSel=0100, WF=1, start -> OutALU=0x80, Flags Z0 C0 N1 O1, done one cycle later.
REQ-021 A=0x18, B=0x18, FunSel=0110, WF=1 -> OutALU=0x00, Z1 C1 N0 O0; then FunSel=1010 with A=0x81 -> OutALU=0x02, C=1, O unchanged.
REQ-022 With C=1, A=0x80, FunSel=1101 -> OutALU=0x01, C=1; repeat with WF=0 -> OutALU updates, Flags unchanged.
REQ-023 (ALU_MUL_EN) A=0x5E, B=0x03, FunSel=1111 -> busy high for 8 cycles, then OutALU=0x1A, C=1, done pulse; a start issued mid-MUL is ignored.
REQ-024 Assert rst_n=0 at cycle 4 of a MUL -> OutALU=0x00, Flags=0000, busy=0 immediately, no done pulse; the next start works normally.
